// File: rtl/alu_control_md.sv
// rtl/alu_control_md.sv - MIPS EX-stage ALU control decode with iterative MULT/DIV sequencer and HI/LO
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   Start           EX-stage instruction valid this cycle
//   Inm             immediate-form instruction; Control follows ALUOpFinal
//   ALUOp           main-decoder op class
//   Funct           R-type funct field
//   ALUOpFinal      ALU code for immediate forms
//   RsData, RtData  operands (multiplicand/dividend, multiplier/divisor, MTHI/MTLO source)
//   Control         4-bit ALU control code (combinational)
//   Busy            sequencer active; upstream stalls
//   Hi, Lo          HI/LO registers
//   MdDone          one-cycle pulse after HI/LO are written by MULT/DIV
//   Illegal         Start with unrecognised Funct under ALUOp=10 (combinational)
//
// Build option: ALU_CTRL_DIV_EN enables the DIV/DIVU datapath; without it DIV/DIVU are
// treated as unknown functs.

module alu_control_md #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic              Inm,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    input  logic [3:0]        ALUOpFinal,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    output logic [3:0]        Control,
    output logic              Busy,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo,
    output logic              MdDone,
    output logic              Illegal
);

    localparam int CW = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef ALU_CTRL_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [3:0] ctrl;
    logic       known;

    always_comb begin
        ctrl  = 4'b0010;
        known = 1'b1;
        if (Inm) begin
            ctrl = ALUOpFinal;
        end else begin
            case (ALUOp)
                2'b00: ctrl = 4'b0010;
                2'b01: ctrl = 4'b0110;
                2'b11: ctrl = 4'b0010;
                default: begin
                    case (Funct)
                        F_ADD:   ctrl = 4'b0010;
                        F_SUB:   ctrl = 4'b0110;
                        F_AND:   ctrl = 4'b0000;
                        F_OR:    ctrl = 4'b0001;
                        F_XOR:   ctrl = 4'b0011;
                        F_NOR:   ctrl = 4'b1100;
                        F_SLT:   ctrl = 4'b0111;
                        F_SLTU:  ctrl = 4'b1111;
                        F_SLL:   ctrl = 4'b1000;
                        F_SRL:   ctrl = 4'b1001;
                        F_MULT, F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO:
                                 ctrl = 4'b0010;
`ifdef ALU_CTRL_DIV_EN
                        F_DIV, F_DIVU:
                                 ctrl = 4'b0010;
`endif
                        default: known = 1'b0;
                    endcase
                end
            endcase
        end
    end

    assign Control = ctrl;
    assign Illegal = Start & ~Inm & (ALUOp == 2'b10) & ~known;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    // Multiply: upper half accumulates partial product, lower half shifts out the multiplier.
    // Divide:   upper half is the partial remainder, lower half shifts dividend in / quotient out.
    logic [2*DATA_W-1:0] p_q, p_d;
    logic [DATA_W-1:0]   b_q, b_d;      // multiplicand or divisor magnitude
    logic                neg_q, neg_d;  // product / quotient needs negation
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
`ifdef ALU_CTRL_DIV_EN
    logic                is_div_q, is_div_d;
    logic                neg_rem_q, neg_rem_d;
    logic                dz_q, dz_d;
`endif

    logic accept, is_mul_f, is_div_f, signed_op, sa, sb;
    logic [DATA_W-1:0] mag_a, mag_b;

    assign accept   = Start & ~Inm & (ALUOp == 2'b10) & (state_q == S_IDLE);
    assign is_mul_f = (Funct == F_MULT) | (Funct == F_MULTU);
`ifdef ALU_CTRL_DIV_EN
    assign is_div_f  = (Funct == F_DIV) | (Funct == F_DIVU);
    assign signed_op = (Funct == F_MULT) | (Funct == F_DIV);
`else
    assign is_div_f  = 1'b0;
    assign signed_op = (Funct == F_MULT);
`endif
    assign sa    = signed_op & RsData[DATA_W-1];
    assign sb    = signed_op & RtData[DATA_W-1];
    assign mag_a = sa ? -RsData : RsData;
    assign mag_b = sb ? -RtData : RtData;

    // One shift-add multiply step
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [2*DATA_W-1:0] prod_fix;
    assign mul_sum  = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, p_q[DATA_W-1:1]};
    assign prod_fix = neg_q ? -p_q : p_q;

`ifdef ALU_CTRL_DIV_EN
    // One restoring-divide step. The shifted remainder needs DATA_W+1 bits; the comparison
    // (rather than the sign of a difference) keeps it correct when that top bit is set.
    logic [DATA_W:0]     div_shift, div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] div_next;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    assign div_shift = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_ge ? {div_diff[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1}
                              : {div_shift[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0};
    assign quo_fix   = neg_q ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
    assign rem_fix   = neg_rem_q ? -p_q[2*DATA_W-1:DATA_W] : p_q[2*DATA_W-1:DATA_W];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        b_d       = b_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef ALU_CTRL_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (Funct == F_MTHI) hi_d = RsData;
                    if (Funct == F_MTLO) lo_d = RsData;
                    if (is_mul_f | is_div_f) begin
                        state_d = S_RUN;
                        cnt_d   = CW'(DATA_W - 1);
                        neg_d   = sa ^ sb;
                        p_d     = is_div_f ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
                        b_d     = is_div_f ? mag_b : mag_a;
`ifdef ALU_CTRL_DIV_EN
                        is_div_d  = is_div_f;
                        neg_rem_d = sa;
                        dz_d      = (RtData == '0);
`endif
                    end
                end
            end
            S_RUN: begin
`ifdef ALU_CTRL_DIV_EN
                p_d = is_div_q ? div_next : mul_next;
`else
                p_d = mul_next;
`endif
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
`ifdef ALU_CTRL_DIV_EN
                if (is_div_q) begin
                    // Divide by zero: quotient forced to all ones; remainder already equals the dividend
                    lo_d = dz_q ? {DATA_W{1'b1}} : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
`else
                {hi_d, lo_d} = prod_fix;
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef ALU_CTRL_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign Busy   = (state_q != S_IDLE);
    assign Hi     = hi_q;
    assign Lo     = lo_q;
    assign MdDone = done_q;

endmodule

// File: tb/tb_alu_control_md.sv
// tb/tb_alu_control_md.sv - directed self-checking bench for alu_control_md

module tb_alu_control_md;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Inm;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic [3:0]  ALUOpFinal;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [3:0]  Control;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        MdDone;
    logic        Illegal;

    int tests = 0;
    int fails = 0;
    logic [31:0] prev_lo;

    logic [5:0] ft [0:9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010};
    logic [3:0] ct [0:9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                            4'b1100, 4'b0111, 4'b1111, 4'b1000, 4'b1001};

    alu_control_md #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Inm(Inm), .ALUOp(ALUOp), .Funct(Funct),
        .ALUOpFinal(ALUOpFinal), .RsData(RsData), .RtData(RtData), .Control(Control),
        .Busy(Busy), .Hi(Hi), .Lo(Lo), .MdDone(MdDone), .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one MULT/DIV, scramble operands after accept, and check latency, pulse and result.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_n = 0;
        int pulses = 0;
        logic [31:0] lo_pre = 32'h0;
        logic md_at = 1'b0;
        @(negedge clk);
        Inm = 1'b0; ALUOp = 2'b10; Funct = f; RsData = rs; RtData = rt; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; RsData = 32'hDEADBEEF; RtData = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (Busy) busy_n++;
            if (MdDone) pulses++;
            if (i == 32) lo_pre = Lo;
            if (i == 33) md_at = MdDone;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_n, 33);
        check({tag, "_done_pulses"}, pulses, 1);
        check({tag, "_done_timing"}, md_at, 1'b1);
        check({tag, "_lo_before"}, lo_pre, prev_lo);
        check({tag, "_hi"}, Hi, exp_hi);
        check({tag, "_lo"}, Lo, exp_lo);
        prev_lo = exp_lo;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; Start = 1'b0; Inm = 1'b0; ALUOp = 2'b00; Funct = 6'b0;
        ALUOpFinal = 4'b0; RsData = 32'h0; RtData = 32'h0;
        prev_lo = 32'h0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_busy", Busy, 1'b0);
        check("rst_hi", Hi, 32'h0);
        check("rst_lo", Lo, 32'h0);
        check("rst_mddone", MdDone, 1'b0);
        rst_n = 1'b1;

        // Decode
        @(negedge clk);
        Inm = 1'b1; ALUOpFinal = 4'b0101; ALUOp = 2'b10; Funct = 6'b111111; #1;
        check("dec_inm", Control, 4'b0101);
        Inm = 1'b0; ALUOp = 2'b00; #1;
        check("dec_op00", Control, 4'b0010);
        ALUOp = 2'b01; #1;
        check("dec_op01", Control, 4'b0110);
        ALUOp = 2'b11; #1;
        check("dec_op11", Control, 4'b0010);
        ALUOp = 2'b10;
        for (int i = 0; i < 10; i++) begin
            Funct = ft[i]; #1;
            check($sformatf("dec_funct_%b", ft[i]), Control, ct[i]);
        end
        Funct = 6'b111111; Start = 1'b0; #1;
        check("illegal_nostart", Illegal, 1'b0);
        Start = 1'b1; #1;
        check("illegal_unknown", Illegal, 1'b1);
        check("illegal_ctrl", Control, 4'b0010);
        Funct = 6'b010000; #1;
        check("mfhi_legal", Illegal, 1'b0);
        @(negedge clk);
        Start = 1'b0;
        check("mfhi_nobusy", Busy, 1'b0);

        // Multiply
        run_md("mult_m3x7", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_md("multu_max", 6'b011001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        run_md("mult_negneg", 6'b011000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h6);
        run_md("mult_minmin", 6'b011000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

`ifdef ALU_CTRL_DIV_EN
        run_md("div_m7d2", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_by0", 6'b011010, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        run_md("div_neg_by0", 6'b011010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_md("divu_100d7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("div_min_m1", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
`else
        @(negedge clk);
        Inm = 1'b0; ALUOp = 2'b10; Funct = 6'b011010; RsData = 32'd7; RtData = 32'd2; Start = 1'b1; #1;
        check("nodiv_illegal", Illegal, 1'b1);
        @(negedge clk);
        Funct = 6'b011011; #1;
        check("nodivu_illegal", Illegal, 1'b1);
        check("nodiv_busy", Busy, 1'b0);
        @(negedge clk);
        Start = 1'b0;
        check("nodiv_busy2", Busy, 1'b0);
        check("nodiv_hi", Hi, 32'h40000000);
        check("nodiv_lo", Lo, 32'h0);
`endif

        // Start during RUN is ignored
        @(negedge clk);
        Inm = 1'b0; ALUOp = 2'b10; Funct = 6'b011000; RsData = 32'd5; RtData = 32'd6; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        Funct = 6'b010011; RsData = 32'hAAAA5555; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("hz_busy", Busy, 1'b1);
        check("hz_lo_held", Lo, prev_lo);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (MdDone) found = 1'b1;
        end
        check("hz_done_seen", found, 1'b1);
        check("hz_hi", Hi, 32'h0);
        check("hz_lo", Lo, 32'd30);
        Funct = 6'b010011; RsData = 32'hAAAA5555; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("mtlo_lo", Lo, 32'hAAAA5555);
        check("mtlo_nobusy", Busy, 1'b0);
        check("mtlo_hi_held", Hi, 32'h0);
        Funct = 6'b010001; RsData = 32'h0BADF00D; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("mthi_hi", Hi, 32'h0BADF00D);
        check("mthi_lo_held", Lo, 32'hAAAA5555);

        // Asynchronous reset mid-RUN
        Funct = 6'b011000; RsData = 32'd3; RtData = 32'd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_pre_busy", Busy, 1'b1);
        rst_n = 1'b0; #1;
        check("arst_busy", Busy, 1'b0);
        check("arst_hi", Hi, 32'h0);
        check("arst_lo", Lo, 32'h0);
        check("arst_mddone", MdDone, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_idle", Busy, 1'b0);
        check("arst_lo_after", Lo, 32'h0);
        check("arst_done_after", MdDone, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
